// File: rtl/apb_arb_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : apb_arb_bridge                                                 |
// | Brief   : Round-robin multi-requester APB bridge, fixed SETUP + ACCESS.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_arb_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int DEC_NUMBER = 16,
   parameter int REQ_NUMBER = 4,
   parameter int DEC_SHIFT  = 12
) (
   input  logic                                 pclk,
   input  logic                                 prst,
   input  logic [REQ_NUMBER-1:0]                req_valid,
   output logic [REQ_NUMBER-1:0]                req_ready,
   input  logic [REQ_NUMBER-1:0][ADDR_WIDTH-1:0] req_addr,
   input  logic [REQ_NUMBER-1:0]                req_write,
   input  logic [REQ_NUMBER-1:0][DATA_WIDTH-1:0] req_wdata,
   output logic [REQ_NUMBER-1:0]                rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_rdata,
   output logic                                 rsp_err,
   output logic [ADDR_WIDTH-1:0]                paddr,
   output logic                                 penable,
   output logic [DEC_NUMBER-1:0]                pselx,
   output logic                                 pwrite,
   output logic [DATA_WIDTH-1:0]                pwdata,
   input  logic [DATA_WIDTH-1:0]                prdata
);

   localparam int c_PTR_W = (REQ_NUMBER > 1) ? $clog2(REQ_NUMBER) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_PTR_W-1:0]   r_ptr;
   logic [c_PTR_W-1:0]   r_gnt;
   logic                 r_dec_ok;
   logic                 w_found;
   logic                 w_accept;
   logic [c_PTR_W-1:0]   w_gnt;
   logic [ADDR_WIDTH-1:0] w_index;
   logic                 w_dec_ok;
   logic [DEC_NUMBER-1:0] w_sel;

   // First valid requester scanning upward from the pointer, with wrap.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int i = 0; i < REQ_NUMBER; i++) begin
         if (!w_found && req_valid[(int'(r_ptr) + i) % REQ_NUMBER]) begin
            w_found = 1'b1;
            w_gnt   = c_PTR_W'((int'(r_ptr) + i) % REQ_NUMBER);
         end
      end
   end

   assign w_index  = req_addr[w_gnt] >> DEC_SHIFT;
   assign w_dec_ok = (w_index < ADDR_WIDTH'(DEC_NUMBER));
   assign w_sel    = w_dec_ok ? (DEC_NUMBER'(1) << w_index) : '0;

   always_ff @(posedge pclk) begin
      if (prst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found && !prst) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP:  w_state_nxt = S_ACCESS;
         S_ACCESS: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign req_ready = w_accept ? (REQ_NUMBER'(1) << w_gnt) : '0;

   always_ff @(posedge pclk) begin
      if (prst) begin
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_dec_ok  <= 1'b0;
         paddr     <= '0;
         penable   <= 1'b0;
         pselx     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (w_accept) begin
            paddr    <= req_addr[w_gnt];
            pwrite   <= req_write[w_gnt];
            pwdata   <= req_wdata[w_gnt];
            pselx    <= w_sel;
            r_dec_ok <= w_dec_ok;
            r_gnt    <= w_gnt;
            r_ptr    <= (w_gnt == c_PTR_W'(REQ_NUMBER - 1)) ? '0 : w_gnt + 1'b1;
         end
         if (r_state == S_SETUP) begin
            penable <= 1'b1;
         end
         // Completion: the bus is released in the same edge the response is posted.
         if (r_state == S_ACCESS) begin
            penable   <= 1'b0;
            pselx     <= '0;
            rsp_valid <= REQ_NUMBER'(1) << r_gnt;
            rsp_rdata <= (!pwrite && r_dec_ok) ? prdata : '0;
            rsp_err   <= !r_dec_ok;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_apb_arb_bridge                                              |
// | Brief   : Directed scoreboard bench for the round-robin APB bridge.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_apb_arb_bridge;

   logic             pclk = 1'b0;
   logic             prst = 1'b1;
   logic [3:0]       req_valid = '0;
   logic [3:0]       req_ready;
   logic [3:0][31:0] req_addr = '0;
   logic [3:0]       req_write = '0;
   logic [3:0][63:0] req_wdata = '0;
   logic [3:0]       rsp_valid;
   logic [63:0]      rsp_rdata;
   logic             rsp_err;
   logic [31:0]      paddr;
   logic             penable;
   logic [15:0]      pselx;
   logic             pwrite;
   logic [63:0]      pwdata;
   logic [63:0]      prdata = '0;

   apb_arb_bridge dut (
      .pclk(pclk), .prst(prst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .penable(penable), .pselx(pselx), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int          g;
      logic [63:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;
   int   last_g = -1;
   bit   acc_flag = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: observe at the falling edge, then step past the rising edge.
   task automatic cyc();
      exp_t       e;
      logic [3:0] oh;
      acc_flag = 1'b0;
      @(negedge pclk);
      if (rsp_valid !== 4'b0000) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            e  = q.pop_front();
            oh = 4'b0001 << e.g;
            chk("rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_latency", 64'(cycle), 64'(e.cyc + 3));
         end
      end
      if (req_ready !== 4'b0000) begin
         acc_flag = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
               last_g = i;
               break;
            end
         end
         e.g   = last_g;
         e.err = (req_addr[last_g] >= 32'h0001_0000);
         e.rd  = (req_write[last_g] || e.err) ? 64'd0 : prdata;
         e.cyc = cycle;
         q.push_back(e);
         chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      end
      @(posedge pclk);
      #1;
      cycle++;
   endtask

   task automatic wait_accept(input int exp_g, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (acc_flag) begin
            got = 1'b1;
            break;
         end
      end
      chk(tag, got ? 64'(last_g) : 64'hFFFF, 64'(exp_g));
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && q.size() > 0; i++) cyc();
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int   grants[$];
      int   acc_cyc[$];
      exp_t dropped;

      // Reset with all requesters already valid; one writer among them.
      for (int i = 0; i < 4; i++) begin
         req_addr[i]  = 32'h0000_1010 + (32'(i) << 12);
         req_wdata[i] = 64'(100 + i);
      end
      req_write = 4'b0100;
      req_valid = 4'hF;
      prdata    = 64'h1111_2222_3333_4444;
      prst      = 1'b1;
      cyc();
      cyc();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_pselx", 64'(pselx), 64'd0);
      chk("rst_penable", 64'(penable), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_paddr", 64'(paddr), 64'd0);
      chk("rst_pwdata", pwdata, 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      prst = 1'b0;

      // Round-robin with continuous requests.
      for (int i = 0; i < 30 && grants.size() < 5; i++) begin
         cyc();
         if (acc_flag) begin
            grants.push_back(last_g);
            acc_cyc.push_back(cycle - 1);
         end
      end
      req_valid = 4'h0;
      chk("rr_count", 64'(grants.size()), 64'd5);
      for (int k = 0; k < grants.size(); k++) chk("rr_order", 64'(grants[k]), 64'(k % 4));
      for (int k = 1; k < acc_cyc.size(); k++)
         chk("rr_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
      drain();

      // Pointer is 1: lone request from 3, then everyone.
      req_addr[3] = 32'h0000_2020;
      req_write   = 4'b0000;
      req_valid   = 4'b1000;
      wait_accept(3, "skip_grant");
      req_valid = 4'hF;
      wait_accept(0, "skip_next");
      req_valid = 4'h0;
      drain();

      // Single read from requester 0.
      req_addr[0] = 32'h0000_3010;
      prdata      = 64'hDEAD_BEEF_0123_4567;
      req_valid   = 4'b0001;
      wait_accept(0, "rd_grant");
      req_valid = 4'h0;
      chk("rd_setup_pselx", 64'(pselx), 64'h0008);
      chk("rd_setup_penable", 64'(penable), 64'd0);
      chk("rd_setup_paddr", 64'(paddr), 64'h3010);
      chk("rd_setup_pwrite", 64'(pwrite), 64'd0);
      cyc();
      chk("rd_access_pselx", 64'(pselx), 64'h0008);
      chk("rd_access_penable", 64'(penable), 64'd1);
      drain();

      // Single write from requester 2.
      req_addr[2]  = 32'h0000_F004;
      req_write[2] = 1'b1;
      req_wdata[2] = 64'h55;
      req_valid    = 4'b0100;
      wait_accept(2, "wr_grant");
      req_valid = 4'h0;
      chk("wr_setup_pselx", 64'(pselx), 64'h8000);
      chk("wr_setup_pwrite", 64'(pwrite), 64'd1);
      chk("wr_setup_pwdata", pwdata, 64'h55);
      chk("wr_setup_penable", 64'(penable), 64'd0);
      cyc();
      chk("wr_access_pselx", 64'(pselx), 64'h8000);
      chk("wr_access_pwdata", pwdata, 64'h55);
      chk("wr_access_penable", 64'(penable), 64'd1);
      drain();
      req_write[2] = 1'b0;

      // Decode error: slave index 16.
      req_addr[1] = 32'h0001_0000;
      req_valid   = 4'b0010;
      wait_accept(1, "de_grant");
      req_valid = 4'h0;
      chk("de_setup_pselx", 64'(pselx), 64'd0);
      chk("de_setup_penable", 64'(penable), 64'd0);
      cyc();
      chk("de_access_pselx", 64'(pselx), 64'd0);
      chk("de_access_penable", 64'(penable), 64'd1);
      drain();

      // Reset during ACCESS; pointer would otherwise be 2 afterwards.
      req_addr[1] = 32'h0000_1000;
      req_valid   = 4'b0010;
      wait_accept(1, "ra_grant");
      req_valid = 4'h0;
      chk("ra_setup_pselx", 64'(pselx), 64'h0002);
      cyc();
      chk("ra_access_penable", 64'(penable), 64'd1);
      prst      = 1'b1;
      dropped   = q.pop_back();
      req_valid = 4'hF;
      cyc();
      chk("ra_pselx", 64'(pselx), 64'd0);
      chk("ra_penable", 64'(penable), 64'd0);
      chk("ra_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("ra_req_ready", 64'(req_ready), 64'd0);
      prst = 1'b0;
      wait_accept(0, "ra_post_grant");
      req_valid = 4'h0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
